// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war match engine.
package tug_pkg;

   // Round/match state machine states
   typedef enum logic [1:0] {
      PLAY = 2'd0,
      HOLD = 2'd1,
      OVER = 2'd2
   } state_t;

   // Winner encoding, {left,right}
   localparam logic [1:0] W_NONE  = 2'b00;
   localparam logic [1:0] W_LEFT  = 2'b10;
   localparam logic [1:0] W_RIGHT = 2'b01;

   // CPU opponent LFSR: 10-bit Fibonacci, taps 10 and 7
   localparam int unsigned        LFSR_W      = 10;
   localparam int unsigned        LFSR_TAP_HI = 9;
   localparam int unsigned        LFSR_TAP_LO = 6;
   localparam logic [LFSR_W-1:0]  LFSR_SEED   = 10'h001;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
      return {cur[LFSR_W-2:0], cur[LFSR_TAP_HI] ^ cur[LFSR_TAP_LO]};
   endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchroniser for a raw key followed by a rising-edge detector.
module key_edge (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic press
);

   logic sync1_q, sync2_q, prev_q;

   // Synchroniser chain plus previous-value flop for edge detection
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= key;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign press = sync2_q & ~prev_q;

endmodule

// File: rtl/tug_match_engine.sv
// Tug-of-war playfield with best-of-N scoring, post-round hold and match lockout.
// Optional build macro TUG_CPU_OPP_EN replaces the right player with an LFSR-driven CPU.
module tug_match_engine
   import tug_pkg::*;
#(
   parameter int unsigned NUM_LEDS    = 9,
   parameter int unsigned SCORE_W     = 3,
   parameter int unsigned WIN_SCORE   = 7,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                key_l,
   input  logic                key_r,
   output logic [NUM_LEDS-1:0] leds,
   output logic [SCORE_W-1:0]  score_l,
   output logic [SCORE_W-1:0]  score_r,
   output logic [1:0]          winner,
   output logic                round_done,
   output logic                match_over
);

   localparam int unsigned POS_W  = $clog2(NUM_LEDS);
   localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

   localparam logic [POS_W-1:0]    CENTER     = POS_W'((NUM_LEDS - 1) / 2);
   localparam logic [POS_W-1:0]    POS_MAX    = POS_W'(NUM_LEDS - 1);
   localparam logic [SCORE_W-1:0]  SCORE_LAST = SCORE_W'(WIN_SCORE - 1);
   localparam logic [HOLD_W-1:0]   HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [NUM_LEDS-1:0] LEDS_INIT  = NUM_LEDS'(1) << CENTER;

   logic press_l, press_r;

   key_edge u_edge_l (
      .clk   (clk),
      .rst   (rst),
      .key   (key_l),
      .press (press_l)
   );

`ifdef TUG_CPU_OPP_EN
   logic [LFSR_W-1:0] lfsr_q;
   logic              cpu_fired_q;
   logic              unused_key_r;

   assign unused_key_r = key_r;
   // Never fire on two consecutive cycles so a run of 4'hF still gives one press
   assign press_r = (lfsr_q[3:0] == 4'hF) && !cpu_fired_q;

   // CPU opponent LFSR, free-running in every state
   always_ff @(posedge clk) begin
      if (!rst) begin
         lfsr_q      <= LFSR_SEED;
         cpu_fired_q <= 1'b0;
      end else begin
         lfsr_q      <= lfsr_next(lfsr_q);
         cpu_fired_q <= press_r;
      end
   end
`else
   key_edge u_edge_r (
      .clk   (clk),
      .rst   (rst),
      .key   (key_r),
      .press (press_r)
   );
`endif

   state_t              state_q, state_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic [NUM_LEDS-1:0] leds_q, leds_d;
   logic [SCORE_W-1:0]  score_l_q, score_l_d, score_r_q, score_r_d;
   logic [1:0]          winner_q, winner_d;
   logic                round_done_q, round_done_d;
   logic                match_over_q, match_over_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic                win_l, win_r, win_match;

   // A left win at the far edge takes priority; the opposing press that cycle is dropped
   assign win_l     = (state_q == PLAY) && press_l && (pos_q == POS_MAX);
   assign win_r     = (state_q == PLAY) && press_r && (pos_q == '0) && !win_l;
   assign win_match = (win_l && (score_l_q == SCORE_LAST)) ||
                      (win_r && (score_r_q == SCORE_LAST));

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= PLAY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         PLAY: begin
            if (win_match) begin
               state_d = OVER;
            end else if (win_l || win_r) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (hold_cnt_q == '0) begin
               state_d = PLAY;
            end
         end
         OVER:    state_d = OVER;
         default: state_d = PLAY;
      endcase
   end

   // Datapath next values: position, scores, winner, pulses and hold counter
   always_comb begin
      pos_d        = pos_q;
      score_l_d    = score_l_q;
      score_r_d    = score_r_q;
      winner_d     = winner_q;
      round_done_d = 1'b0;
      match_over_d = match_over_q;
      hold_cnt_d   = hold_cnt_q;
      unique case (state_q)
         PLAY: begin
            if (win_l) begin
               score_l_d    = score_l_q + SCORE_W'(1);
               winner_d     = W_LEFT;
               round_done_d = 1'b1;
            end else if (win_r) begin
               score_r_d    = score_r_q + SCORE_W'(1);
               winner_d     = W_RIGHT;
               round_done_d = 1'b1;
            end else if (press_l && !press_r) begin
               pos_d = pos_q + POS_W'(1);
            end else if (press_r && !press_l) begin
               pos_d = pos_q - POS_W'(1);
            end
            if (win_match) begin
               match_over_d = 1'b1;
            end else if (win_l || win_r) begin
               hold_cnt_d = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (hold_cnt_q == '0) begin
               pos_d    = CENTER;
               winner_d = W_NONE;
            end else begin
               hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
         end
         default: ;
      endcase
      leds_d        = '0;
      leds_d[pos_d] = 1'b1;
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         pos_q        <= CENTER;
         leds_q       <= LEDS_INIT;
         score_l_q    <= '0;
         score_r_q    <= '0;
         winner_q     <= W_NONE;
         round_done_q <= 1'b0;
         match_over_q <= 1'b0;
         hold_cnt_q   <= '0;
      end else begin
         pos_q        <= pos_d;
         leds_q       <= leds_d;
         score_l_q    <= score_l_d;
         score_r_q    <= score_r_d;
         winner_q     <= winner_d;
         round_done_q <= round_done_d;
         match_over_q <= match_over_d;
         hold_cnt_q   <= hold_cnt_d;
      end
   end

   // Outputs come straight from registers
   always_comb begin
      leds       = leds_q;
      score_l    = score_l_q;
      score_r    = score_r_q;
      winner     = winner_q;
      round_done = round_done_q;
      match_over = match_over_q;
   end

endmodule

// File: tb/tb_tug_match_engine.sv
// Self-checking bench for tug_match_engine (NUM_LEDS=9, HOLD_CYCLES=4, WIN_SCORE=2).
module tb_tug_match_engine;

   localparam int N    = 9;
   localparam int HOLD = 4;
   localparam int WIN  = 2;
   localparam int CTR  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_l = 1'b0;
   logic       key_r = 1'b0;
   logic [8:0] leds;
   logic [2:0] score_l, score_r;
   logic [1:0] winner;
   logic       round_done, match_over;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   tug_match_engine #(
      .NUM_LEDS    (N),
      .SCORE_W     (3),
      .WIN_SCORE   (WIN),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_l      (key_l),
      .key_r      (key_r),
      .leds       (leds),
      .score_l    (score_l),
      .score_r    (score_r),
      .winner     (winner),
      .round_done (round_done),
      .match_over (match_over)
   );

   // Reference model: game rules on plain integers; mode 0=play, 1=hold, 2=over
   int m_pos = CTR, m_sl = 0, m_sr = 0, m_win = 0, m_hold = 0, m_mode = 0;
   bit m_rd = 0, m_mo = 0;
   bit hl[3], hr[3];   // key samples from 1, 2 and 3 edges ago
   int m_lfsr = 1;
   bit m_cpu_prev = 0;

   function automatic logic [8:0] exp_leds();
      return 9'(1) << m_pos;
   endfunction

   task automatic model_edge();
      bit pl, pr;
      if (!rst) begin
         m_pos = CTR; m_sl = 0; m_sr = 0; m_win = 0; m_hold = 0; m_mode = 0;
         m_rd = 0; m_mo = 0; m_lfsr = 1; m_cpu_prev = 0;
         for (int i = 0; i < 3; i++) begin
            hl[i] = 0;
            hr[i] = 0;
         end
         return;
      end
      // A press lands two edges after the key is first seen high
      pl = hl[1] && !hl[2];
`ifdef TUG_CPU_OPP_EN
      pr = ((m_lfsr & 15) == 15) && !m_cpu_prev;
      m_cpu_prev = pr;
      m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1)) & 1023;
`else
      pr = hr[1] && !hr[2];
`endif
      hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = key_l;
      hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = key_r;
      m_rd = 0;
      if (m_mode == 0) begin
         if ((pl && m_pos == N - 1) || (pr && m_pos == 0)) begin
            if (pl && m_pos == N - 1) begin
               m_sl++;
               m_win = 2;
            end else begin
               m_sr++;
               m_win = 1;
            end
            m_rd = 1;
            if (m_sl == WIN || m_sr == WIN) begin
               m_mode = 2;
               m_mo = 1;
            end else begin
               m_mode = 1;
               m_hold = HOLD;
            end
         end else if (pl && !pr) begin
            m_pos++;
         end else if (pr && !pl) begin
            m_pos--;
         end
      end else if (m_mode == 1) begin
         m_hold--;
         if (m_hold == 0) begin
            m_mode = 0;
            m_pos = CTR;
            m_win = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Press and release, then wait until the press has taken effect
   task automatic pulse(input bit left, input bit right);
      key_l = left;
      key_r = right;
      tick();
      key_l = 1'b0;
      key_r = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      n_tests++;
      if (leds !== 9'b000010000) begin
         n_fail++; $display("FAIL reset_leds: got %b want %b", leds, 9'b000010000);
      end
      n_tests++;
      if (score_l !== 3'd0) begin
         n_fail++; $display("FAIL reset_score_l: got %0d want 0", score_l);
      end
      n_tests++;
      if (score_r !== 3'd0) begin
         n_fail++; $display("FAIL reset_score_r: got %0d want 0", score_r);
      end
      n_tests++;
      if (winner !== 2'b00) begin
         n_fail++; $display("FAIL reset_winner: got %b want 00", winner);
      end
      n_tests++;
      if (round_done !== 1'b0) begin
         n_fail++; $display("FAIL reset_round_done: got %b want 0", round_done);
      end
      n_tests++;
      if (match_over !== 1'b0) begin
         n_fail++; $display("FAIL reset_match_over: got %b want 0", match_over);
      end
   endtask

`ifndef TUG_CPU_OPP_EN
   task automatic test_held_key();
      key_l = 1'b1;
      tick();
      tick();
      n_tests++;
      if (leds !== 9'b000010000) begin
         n_fail++; $display("FAIL held_latency: got %b want %b", leds, 9'b000010000);
      end
      tick();
      n_tests++;
      if (leds !== 9'b000100000) begin
         n_fail++; $display("FAIL held_first_move: got %b want %b", leds, 9'b000100000);
      end
      for (int i = 0; i < 7; i++) tick();
      n_tests++;
      if (leds !== 9'b000100000) begin
         n_fail++; $display("FAIL held_single_press: got %b want %b", leds, 9'b000100000);
      end
      key_l = 1'b0;
      pulse(1'b0, 1'b1);
      n_tests++;
      if (leds !== 9'b000010000) begin
         n_fail++; $display("FAIL held_right_back: got %b want %b", leds, 9'b000010000);
      end
   endtask

   task automatic test_both_pressed();
      pulse(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (round_done !== 1'b0) begin
            n_fail++; $display("FAIL both_round_done: got %b want 0", round_done);
         end
         tick();
      end
      n_tests++;
      if (leds !== 9'b000010000) begin
         n_fail++; $display("FAIL both_leds: got %b want %b", leds, 9'b000010000);
      end
   endtask

   task automatic test_left_round();
      logic [8:0] want;
      for (int p = 1; p <= 4; p++) begin
         pulse(1'b1, 1'b0);
         want = 9'(1) << (CTR + p);
         n_tests++;
         if (leds !== want) begin
            n_fail++; $display("FAIL round_step%0d: got %b want %b", p, leds, want);
         end
      end
      pulse(1'b1, 1'b0);
      n_tests++;
      if (score_l !== 3'd1) begin
         n_fail++; $display("FAIL round_score_l: got %0d want 1", score_l);
      end
      n_tests++;
      if (winner !== 2'b10) begin
         n_fail++; $display("FAIL round_winner: got %b want 10", winner);
      end
      n_tests++;
      if (round_done !== 1'b1) begin
         n_fail++; $display("FAIL round_done_pulse: got %b want 1", round_done);
      end
      n_tests++;
      if (leds !== 9'b100000000) begin
         n_fail++; $display("FAIL round_edge_led: got %b want %b", leds, 9'b100000000);
      end
      key_l = 1'b1;
      tick();
      n_tests++;
      if (round_done !== 1'b0) begin
         n_fail++; $display("FAIL round_done_width: got %b want 0", round_done);
      end
      key_l = 1'b0;
      tick();
      tick();
      n_tests++;
      if (leds !== 9'b100000000 || winner !== 2'b10) begin
         n_fail++; $display("FAIL hold_state: got %b/%b want 100000000/10", leds, winner);
      end
      tick();
      n_tests++;
      if (leds !== 9'b000010000 || winner !== 2'b00) begin
         n_fail++; $display("FAIL hold_exit: got %b/%b want 000010000/00", leds, winner);
      end
      for (int i = 0; i < 3; i++) tick();
      n_tests++;
      if (leds !== 9'b000010000 || score_l !== 3'd1) begin
         n_fail++; $display("FAIL hold_press_dropped: got %b/%0d want 000010000/1", leds, score_l);
      end
   endtask

   task automatic test_match_over();
      for (int p = 0; p < 5; p++) pulse(1'b1, 1'b0);
      n_tests++;
      if (score_l !== 3'd2) begin
         n_fail++; $display("FAIL match_score_l: got %0d want 2", score_l);
      end
      n_tests++;
      if (match_over !== 1'b1) begin
         n_fail++; $display("FAIL match_over_set: got %b want 1", match_over);
      end
      n_tests++;
      if (leds !== 9'b100000000 || winner !== 2'b10) begin
         n_fail++; $display("FAIL match_leds: got %b/%b want 100000000/10", leds, winner);
      end
      pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) tick();
      n_tests++;
      if (leds !== 9'b100000000 || score_l !== 3'd2 || score_r !== 3'd0 || match_over !== 1'b1)
      begin
         n_fail++; $display("FAIL match_frozen: got %b/%0d/%0d/%b", leds, score_l, score_r,
                            match_over);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      n_tests++;
      if (leds !== 9'b000010000 || score_l !== 3'd0 || winner !== 2'b00 || match_over !== 1'b0)
      begin
         n_fail++; $display("FAIL match_reset: got %b/%0d/%b/%b", leds, score_l, winner,
                            match_over);
      end
   endtask
`else
   task automatic test_cpu();
      bit found = 0;
      rst = 1'b0;
      key_r = 1'b1;
      tick();
      rst = 1'b1;
      for (int c = 0; c < 1100 && !found; c++) begin
         tick();
         n_tests++;
         if (leds !== exp_leds()) begin
            n_fail++; $display("FAIL cpu_track: got %b want %b", leds, exp_leds());
         end
         if (m_pos != CTR) found = 1;
      end
      n_tests++;
      if (!found || leds !== 9'b000001000) begin
         n_fail++; $display("FAIL cpu_first_press: got %b want %b", leds, 9'b000001000);
      end
      key_r = 1'b0;
   endtask
`endif

   task automatic test_random();
      int bias, pl_rng, pr_rng;
      for (int i = 0; i < 3000; i++) begin
         bias   = (i / 150) % 3;
         pl_rng = (bias == 0) ? 1 : 5;
         pr_rng = (bias == 1) ? 1 : 5;
         if (bias == 2) begin
            pl_rng = 3;
            pr_rng = 3;
         end
         if ($urandom_range(0, pl_rng) == 0) key_l = ~key_l;
         if ($urandom_range(0, pr_rng) == 0) key_r = ~key_r;
         rst = ($urandom_range(0, m_mo ? 19 : 399) != 0);
         tick();
         n_tests++;
         if (leds !== exp_leds() || score_l !== 3'(m_sl) || score_r !== 3'(m_sr) ||
             winner !== 2'(m_win) || round_done !== m_rd || match_over !== m_mo) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got %b/%0d/%0d/%b/%b/%b want %b/%0d/%0d/%0d/%b/%b",
                     i, leds, score_l, score_r, winner, round_done, match_over,
                     exp_leds(), m_sl, m_sr, m_win, m_rd, m_mo);
         end
      end
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
`ifndef TUG_CPU_OPP_EN
      test_held_key();
      test_both_pressed();
      test_left_round();
      test_match_over();
`else
      test_cpu();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tug_match_engine.md
Name: tug_match_engine

Overview:
- Parametrised successor to the two-player tug-of-war playfield: one block holding the key synchronisers, press edge detection, light position, round win detection, per-player scoring and a round/match state machine.
- Sits between the raw board keys and the LED, score and hex display logic.
- Adds parametrised field width, best-of-N scoring, a post-round hold period and match lockout.

Parameters:
- NUM_LEDS, 9, playfield width; odd, >=3; CENTER = (NUM_LEDS-1)/2.
- SCORE_W, 3, width of each score counter.
- WIN_SCORE, 7, round wins needed to take the match; 1..2**SCORE_W-1.
- HOLD_CYCLES, 4, clocks spent in HOLD after a round win; >=1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous, active-low reset.
- key_l, input, 1, raw left-player press, active-high, asynchronous to clk.
- key_r, input, 1, raw right-player press, active-high, asynchronous to clk.
- leds, output, NUM_LEDS, playfield; bit NUM_LEDS-1 is the leftmost LED.
- score_l, output, SCORE_W, left-player round wins.
- score_r, output, SCORE_W, right-player round wins.
- winner, output, 2, {left,right} winner of the last round or match; 00 = none.
- round_done, output, 1, one-cycle pulse when a round is won.
- match_over, output, 1, high once either score reaches WIN_SCORE.

Behaviour:
- Reset (rst==0 at a clk edge), all registered:
  - state=PLAY, pos=CENTER, leds one-hot at CENTER.
  - Scores 0, winner 00, round_done 0, match_over 0.
  - Sync, prev and hold-counter flops cleared.
  - Reset applied mid-round, mid-HOLD or in OVER returns to these values on the same edge.
- Input path, per key:
  - Two-flop synchroniser feeding a rising-edge detect: press = sync2 & ~prev.
  - A held key yields exactly one press.
  - Latency: key first sampled high at edge E0 -> pos/leds change at edge E0+2, visible after the third edge.
- State PLAY:
  - Left press only: pos+1. Right press only: pos-1.
  - Both presses in the same cycle: no change.
  - Left press with pos==NUM_LEDS-1: left wins the round. pos is not incremented, there is no wrap-around, and the right player's press is ignored that cycle.
  - Right press with pos==0: right wins the round, symmetric to the left case.
- Round win, on the same edge:
  - Winner's score +1.
  - winner set to the winning side; 10 = left, 01 = right.
  - round_done=1 for exactly one cycle.
  - leds hold the winning edge LED.
- Next state after a round win:
  - If the new score == WIN_SCORE -> OVER.
  - Otherwise -> HOLD, with the hold counter loaded to HOLD_CYCLES-1.
- State HOLD:
  - Presses are discarded; edge detectors keep running, so a key held through HOLD does not fire on exit.
  - The counter decrements each cycle.
  - At counter==0: next edge -> PLAY, pos=CENTER, winner=00.
- State OVER:
  - match_over=1, winner held, leds show the winner edge LED only, scores frozen.
  - Leaves only on reset.
- Scores never exceed WIN_SCORE, so there is no overflow path.

Optional Feature:
- Macro: TUG_CPU_OPP_EN.
- Defined:
  - key_r is ignored; the right player is a CPU.
  - A 10-bit Fibonacci LFSR (taps 10,7; seed 10'h001 on reset) shifts every clk.
  - A right press is generated when lfsr[3:0]==4'hF and no CPU press fired the previous cycle.
  - These presses feed the same PLAY logic without the synchroniser delay.
  - The LFSR runs in all states.
- Undefined: no LFSR is built; key_r drives the right player as described above.

Decomposition:
- Package tug_pkg:
  - state enum {PLAY, HOLD, OVER}.
  - Winner encoding constants W_NONE, W_LEFT, W_RIGHT.
  - LFSR width, tap and seed constants.
- Sub-module key_edge (clk, rst, key -> press): synchroniser plus edge detect, instantiated twice.

Test Plan (NUM_LEDS=9, HOLD_CYCLES=4, WIN_SCORE=2 unless noted):
- Reset then idle 5 cycles -> leds=9'b000010000, scores 0, winner 00, match_over 0.
- key_l held high 10 cycles -> pos moves exactly once to 5, leds=9'b000100000, with the change after the third edge.
- key_l and key_r pulsed in the same cycle -> leds unchanged, no round_done.
- 5 distinct key_l presses from center:
  - The 5th press (pos==8) -> score_l=1, winner=10, round_done pulse of exactly 1 cycle.
  - 4 cycles of HOLD with presses ignored.
  - Then leds back to center and winner=00.
- Second left round win:
  - -> score_l=2, match_over=1, OVER state, leds=9'b100000000.
  - Further presses do nothing.
  - rst=0 for 1 cycle -> all reset values.
- With TUG_CPU_OPP_EN: hold key_r=1 and reset -> first CPU press on the first cycle lfsr[3:0]==4'hF; the pos decrement checked against a reference LFSR model.
